// File: rtl/mbinit_cal_module.sv
// MBINIT CAL substate controller: sends MBINIT_CAL_Done_req over the sideband,
// waits for Done_resp from the remote die, then reports completion once the
// partner side has also finished.
// Optional feature: define CAL_TIMEOUT_EN to compile in the timeout counter and
// the ERROR state that raises o_train_error_req.
module mbinit_cal_module #(
  parameter int unsigned TIMEOUT_W      = 20,
  parameter int unsigned TIMEOUT_CYCLES = 800000
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       i_MBINIT_PARAM_end,
  input  logic [3:0] i_RX_SbMessage,
  input  logic       i_msg_valid,
  input  logic       i_Busy_SideBand,
  input  logic       i_falling_edge_busy,
  input  logic       i_partner_end,
  output logic [3:0] o_TX_SbMessage,
  output logic       o_ValidOutDatat_Module,
  output logic       o_MBINIT_CAL_Module_end,
  output logic       o_MBINIT_CAL_end,
  output logic       o_train_error_req
);

  localparam logic [3:0] MsgDoneReq  = 4'b0001;
  localparam logic [3:0] MsgDoneResp = 4'b0010;

`ifdef CAL_TIMEOUT_EN
  typedef enum logic [2:0] {
    StIdle, StWaitBusy, StSendReq, StWaitResp, StDone, StError
  } state_e;
`else
  typedef enum logic [2:0] {
    StIdle, StWaitBusy, StSendReq, StWaitResp, StDone
  } state_e;
`endif

  state_e state_q, state_d;
  logic   resp_seen_q, resp_seen_d;
  logic   resp_now;

  assign resp_now = i_msg_valid && (i_RX_SbMessage == MsgDoneResp);

`ifdef CAL_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] CntLast = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 timeout;

  assign timeout = (cnt_q >= CntLast);

  // Elapsed-cycle counter: cleared in IDLE, counts while a request is pending, saturates.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StIdle) begin
      cnt_d = '0;
    end else if ((state_q == StWaitBusy || state_q == StSendReq || state_q == StWaitResp) &&
                 (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_W == 0) && (TIMEOUT_CYCLES == 0);
`endif

  // Next-state logic; dropping the enable aborts from anywhere.
  always_comb begin
    state_d = state_q;
    if (state_q != StIdle && !i_MBINIT_PARAM_end) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:     if (i_MBINIT_PARAM_end) state_d = StWaitBusy;
        StWaitBusy: begin
`ifdef CAL_TIMEOUT_EN
          if (timeout) state_d = StError;
          else
`endif
          if (!i_Busy_SideBand) state_d = StSendReq;
        end
        StSendReq: begin
`ifdef CAL_TIMEOUT_EN
          if (timeout) state_d = StError;
          else
`endif
          if (i_falling_edge_busy) state_d = StWaitResp;
        end
        StWaitResp: begin
          // A response beats a coincident timeout.
          if (resp_seen_q || resp_now) state_d = StDone;
`ifdef CAL_TIMEOUT_EN
          else if (timeout) state_d = StError;
`endif
        end
        StDone:     state_d = StDone;
`ifdef CAL_TIMEOUT_EN
        StError:    state_d = StError;
`endif
        default:    state_d = StIdle;
      endcase
    end
  end

  // Sticky capture of a response that arrives before the request has left.
  always_comb begin
    resp_seen_d = resp_seen_q;
    if (state_q == StIdle)                     resp_seen_d = 1'b0;
    else if (state_q == StSendReq && resp_now) resp_seen_d = 1'b1;
  end

  // State and sticky flag registers.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      resp_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      resp_seen_q <= resp_seen_d;
    end
  end

  // Registered outputs decoded from the next state.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      o_ValidOutDatat_Module  <= 1'b0;
      o_TX_SbMessage          <= 4'b0000;
      o_MBINIT_CAL_Module_end <= 1'b0;
      o_MBINIT_CAL_end        <= 1'b0;
    end else begin
      o_ValidOutDatat_Module  <= (state_d == StSendReq);
      o_TX_SbMessage          <= (state_d == StSendReq) ? MsgDoneReq : 4'b0000;
      o_MBINIT_CAL_Module_end <= (state_d == StDone);
      // Staying in DONE keeps an abort from leaving CAL_end high for a cycle.
      o_MBINIT_CAL_end        <= (state_q == StDone) && (state_d == StDone) && i_partner_end;
    end
  end

`ifdef CAL_TIMEOUT_EN
  // Error request mirrors the ERROR state.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) o_train_error_req <= 1'b0;
    else        o_train_error_req <= (state_d == StError);
  end
`else
  assign o_train_error_req = 1'b0;
`endif

endmodule

// File: tb/tb_mbinit_cal_module.sv
// Self-checking bench for mbinit_cal_module: directed vector table, hand-written
// corner sequences and randomized traffic against a behavioural model.
module tb_mbinit_cal_module;

  localparam int unsigned TW = 20;
  localparam int unsigned TC = 16;

  logic       CLK = 1'b0;
  logic       rst_n;
  logic       en, busy, fall, mv, partner;
  logic [3:0] rx_msg;
  logic [3:0] tx_msg;
  logic       o_valid, o_mod_end, o_cal_end, o_err;

  int total = 0;
  int bad   = 0;

  mbinit_cal_module #(.TIMEOUT_W(TW), .TIMEOUT_CYCLES(TC)) dut (
    .CLK                     (CLK),
    .rst_n                   (rst_n),
    .i_MBINIT_PARAM_end      (en),
    .i_RX_SbMessage          (rx_msg),
    .i_msg_valid             (mv),
    .i_Busy_SideBand         (busy),
    .i_falling_edge_busy     (fall),
    .i_partner_end           (partner),
    .o_TX_SbMessage          (tx_msg),
    .o_ValidOutDatat_Module  (o_valid),
    .o_MBINIT_CAL_Module_end (o_mod_end),
    .o_MBINIT_CAL_end        (o_cal_end),
    .o_train_error_req       (o_err)
  );

  always #5 CLK = ~CLK;

  // ---------------- behavioural model ----------------
  localparam int POff = 0, PWaitCh = 1, PReq = 2, PAwait = 3, PDone = 4, PErr = 5;

  int         m_ph;
  bit         m_resp;
  longint     m_elapsed;
  logic       e_valid, e_mod, e_cal, e_err;
  logic [3:0] e_msg;

  function automatic void model_reset();
    m_ph = POff; m_resp = 0; m_elapsed = 0;
    e_valid = 0; e_msg = 4'h0; e_mod = 0; e_cal = 0; e_err = 0;
  endfunction

  function automatic void model_clock();
    int nxt = m_ph;
    bit rnow = mv && (rx_msg == 4'b0010);
    bit pending = (m_ph == PWaitCh) || (m_ph == PReq) || (m_ph == PAwait);
    bit expired = 0;
`ifdef CAL_TIMEOUT_EN
    expired = pending && (m_elapsed >= TC - 1);
`endif
    if (m_ph != POff && !en)                     nxt = POff;
    else if (m_ph == POff)                       nxt = en ? PWaitCh : POff;
    else if (m_ph == PAwait && (m_resp || rnow)) nxt = PDone;
    else if (expired)                            nxt = PErr;
    else if (m_ph == PWaitCh && !busy)           nxt = PReq;
    else if (m_ph == PReq && fall)               nxt = PAwait;
    e_cal = (m_ph == PDone) && (nxt == PDone) && partner;
    if (m_ph == POff)              m_resp = 0;
    else if (m_ph == PReq && rnow) m_resp = 1;
    if (m_ph == POff) m_elapsed = 0;
    else if (pending && m_elapsed < (64'd1 << TW) - 1) m_elapsed++;
    m_ph    = nxt;
    e_valid = (nxt == PReq);
    e_msg   = e_valid ? 4'b0001 : 4'b0000;
    e_mod   = (nxt == PDone);
    e_err   = (nxt == PErr);
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_model(input string name);
    chk({name, "_valid"},   {3'b0, o_valid},   {3'b0, e_valid});
    chk({name, "_msg"},     tx_msg,            e_msg);
    chk({name, "_mod_end"}, {3'b0, o_mod_end}, {3'b0, e_mod});
    chk({name, "_cal_end"}, {3'b0, o_cal_end}, {3'b0, e_cal});
    chk({name, "_err"},     {3'b0, o_err},     {3'b0, e_err});
  endtask

  task automatic drive(input logic a_en, input logic a_busy, input logic a_fall,
                       input logic a_mv, input logic [3:0] a_msg, input logic a_partner);
    en = a_en; busy = a_busy; fall = a_fall; mv = a_mv; rx_msg = a_msg; partner = a_partner;
  endtask

  task automatic step();
    @(posedge CLK);
    model_clock();
    #1;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic       en, busy, fall, mv;
    logic [3:0] msg;
    logic       partner;
    logic       ev;
    logic [3:0] em;
    logic       emod, ecal;
  } vec_t;

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0}; // -> wait busy
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 4'h1, 1'b0, 1'b0}; // -> send req
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 4'h1, 1'b0, 1'b0}; // sending
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0}; // sent
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'h1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0}; // Done_req ignored
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'h2, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0}; // Done_resp
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1}; // partner done
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0}; // partner drops
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0}; // enable drops
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0};

    // Reset state.
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 4'h0, 0);
    model_reset();
    #2;
    check_model("reset");
    repeat (2) @(posedge CLK);
    #1;
    drive(1, 0, 0, 0, 4'h0, 0);
    #1;
    check_model("reset_hold");
    drive(0, 0, 0, 0, 4'h0, 0);
    @(negedge CLK);
    rst_n = 1'b1;

    // Nominal handshake from the table.
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].en, tbl[i].busy, tbl[i].fall, tbl[i].mv, tbl[i].msg, tbl[i].partner);
      step();
      chk($sformatf("tbl%0d_valid", i),   {3'b0, o_valid},   {3'b0, tbl[i].ev});
      chk($sformatf("tbl%0d_msg", i),     tx_msg,            tbl[i].em);
      chk($sformatf("tbl%0d_mod_end", i), {3'b0, o_mod_end}, {3'b0, tbl[i].emod});
      chk($sformatf("tbl%0d_cal_end", i), {3'b0, o_cal_end}, {3'b0, tbl[i].ecal});
      chk($sformatf("tbl%0d_err", i),     {3'b0, o_err},     4'h0);
    end

    // Busy held for 10 cycles after enable.
    drive(1, 1, 0, 0, 4'h0, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("busy_held_valid", {3'b0, o_valid}, 4'h0);
    end
    drive(1, 0, 0, 0, 4'h0, 0);
    step();
    chk("busy_drop_valid", {3'b0, o_valid}, 4'h1);
    chk("busy_drop_msg", tx_msg, 4'h1);
    check_model("busy_drop");

    // Early response during SEND_REQ.
    drive(1, 1, 0, 1, 4'h2, 0);
    step();
    chk("early_still_req", {3'b0, o_valid}, 4'h1);
    chk("early_no_done", {3'b0, o_mod_end}, 4'h0);
    drive(1, 1, 0, 0, 4'h0, 0);
    step();
    drive(1, 0, 1, 0, 4'h0, 0);
    step();
    chk("early_sent_valid", {3'b0, o_valid}, 4'h0);
    drive(1, 0, 0, 0, 4'h0, 0);
    step();
    chk("early_done", {3'b0, o_mod_end}, 4'h1);
    check_model("early");

    // Abort during WAIT_RESP; a late response must not complete anything.
    drive(0, 0, 0, 0, 4'h0, 0);
    step();
    drive(1, 0, 0, 0, 4'h0, 0);
    step();
    step();
    drive(1, 0, 1, 0, 4'h0, 0);
    step();
    drive(0, 0, 0, 0, 4'h0, 0);
    step();
    check_model("abort");
    chk("abort_mod_end", {3'b0, o_mod_end}, 4'h0);
    drive(0, 0, 0, 1, 4'h2, 0);
    step();
    check_model("abort_late_resp");
    drive(1, 1, 0, 1, 4'h2, 0);
    step();
    chk("resp_in_wait_busy", {3'b0, o_mod_end}, 4'h0);
    drive(1, 1, 0, 0, 4'h0, 0);
    step();
    check_model("resp_ignored");

    // Asynchronous reset in the middle of SEND_REQ.
    drive(1, 0, 0, 0, 4'h0, 0);
    step();
    chk("pre_reset_valid", {3'b0, o_valid}, 4'h1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_model("async_reset");
    @(negedge CLK);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 4'h0, 0);
    step();
    check_model("after_reset");

`ifdef CAL_TIMEOUT_EN
    // No response: error 16 cycles after leaving IDLE.
    drive(1, 1, 0, 0, 4'h0, 0);
    for (int k = 1; k <= 16; k++) begin
      step();
      chk("timeout_not_yet", {3'b0, o_err}, 4'h0);
    end
    step();
    chk("timeout_err", {3'b0, o_err}, 4'h1);
    check_model("timeout");
    drive(0, 0, 0, 0, 4'h0, 0);
    step();
    chk("timeout_clear", {3'b0, o_err}, 4'h0);
    // Response coinciding with expiry wins.
    for (int k = 1; k <= 16; k++) begin
      drive(1, 0, (k == 3), 0, 4'h0, 0);
      step();
    end
    drive(1, 0, 0, 1, 4'h2, 0);
    step();
    chk("race_done", {3'b0, o_mod_end}, 4'h1);
    chk("race_no_err", {3'b0, o_err}, 4'h0);
    drive(0, 0, 0, 0, 4'h0, 0);
    step();
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] m;
      int unsigned pick;
      pick = $urandom_range(0, 3);
      m = (pick == 0) ? 4'b0001 : (pick == 3) ? 4'($urandom) : 4'b0010;
      drive(($urandom_range(0, 39) != 0), ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0), m,
            ($urandom_range(0, 1) == 1));
      step();
      check_model("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mbinit_cal_module.md
MBINIT_CAL_MODULE -- requirements
Module: mbinit_cal_module

Interface
REQ-001 Parameter TIMEOUT_W, default 20; width of the timeout counter in bits.
REQ-002 Parameter TIMEOUT_CYCLES, default 800000; cycles allowed from request start to response, valid only under CAL_TIMEOUT_EN.
REQ-003 CLK  in  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 i_MBINIT_PARAM_end  in  1  level enable; high = PARAM substate finished, CAL may run.
REQ-006 i_RX_SbMessage  in  4  decoded received sideband message.
REQ-007 i_msg_valid  in  1  i_RX_SbMessage valid this cycle.
REQ-008 i_Busy_SideBand  in  1  sideband transmitter busy.
REQ-009 i_falling_edge_busy  in  1  one-cycle pulse when busy falls, i.e. the message was sent.
REQ-010 i_partner_end  in  1  partner-side CAL handshake complete (level).
REQ-011 o_TX_SbMessage  out  4  message to transmit; 4'b0001 = MBINIT_CAL_Done_req.
REQ-012 o_ValidOutDatat_Module  out  1  o_TX_SbMessage valid request to the sideband.
REQ-013 o_MBINIT_CAL_Module_end  out  1  local request acknowledged by the remote die.
REQ-014 o_MBINIT_CAL_end  out  1  whole CAL substate done; feeds the next MBINIT stage.
REQ-015 o_train_error_req  out  1  timeout error to the LTSM; constant 0 without CAL_TIMEOUT_EN.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT_BUSY, SEND_REQ, WAIT_RESP, DONE and ERROR, with a registered current state.
REQ-017 IDLE -> WAIT_BUSY when i_MBINIT_PARAM_end=1.
REQ-018 WAIT_BUSY -> SEND_REQ when i_Busy_SideBand=0.
REQ-019 SEND_REQ -> WAIT_RESP on i_falling_edge_busy=1.
REQ-020 WAIT_RESP -> DONE when resp_seen=1, or when i_msg_valid=1 with i_RX_SbMessage=4'b0010 (Done_resp).
REQ-021 DONE is held until i_MBINIT_PARAM_end falls.
REQ-022 From every non-IDLE state, i_MBINIT_PARAM_end=0 SHALL force IDLE next cycle; this takes priority over all other transitions.
REQ-023 Outputs SHALL be registered and decoded from next state, so they take effect one cycle after the triggering input.
REQ-024 In SEND_REQ, the outputs SHALL be o_ValidOutDatat_Module=1 and o_TX_SbMessage=4'b0001.
REQ-025 In all other states, the outputs SHALL be o_ValidOutDatat_Module=0 and o_TX_SbMessage=4'b0000.
REQ-026 o_MBINIT_CAL_Module_end SHALL be 1 exactly while the state is DONE.
REQ-027 o_MBINIT_CAL_end SHALL be the registered AND of (state==DONE) and i_partner_end, so it rises one cycle after both conditions hold.
REQ-028 Sticky flag resp_seen SHALL set on a valid Done_resp received in SEND_REQ, so an early response is not lost.
REQ-029 resp_seen SHALL clear in IDLE.
REQ-030 Received messages other than Done_resp, including Done_req, SHALL be ignored by this block.
REQ-031 If a valid Done_resp arrives in WAIT_BUSY, it SHALL be ignored, because no request is outstanding.

Reset
REQ-032 While rst_n=0, the block SHALL hold state IDLE, resp_seen=0, counter=0 and all outputs 0.
REQ-033 Reset asserted mid-handshake SHALL abort immediately without completing any sideband transfer.

Configuration
REQ-034 Macro CAL_TIMEOUT_EN, when defined, SHALL compile in a TIMEOUT_W-bit counter.
REQ-035 The counter SHALL clear in IDLE and increment each cycle in WAIT_BUSY, SEND_REQ and WAIT_RESP.
REQ-036 The counter SHALL saturate and never wrap.
REQ-037 When the counter reaches TIMEOUT_CYCLES-1, the FSM SHALL go to ERROR.
REQ-038 ERROR SHALL drive o_train_error_req=1 until i_MBINIT_PARAM_end=0, then return to IDLE.
REQ-039 If a valid Done_resp and timeout expiry coincide in WAIT_RESP, the response SHALL win and the FSM goes to DONE.
REQ-040 With CAL_TIMEOUT_EN undefined, there SHALL be no counter and no ERROR state, o_train_error_req SHALL be tied 0, and the FSM SHALL wait indefinitely.

Verification
REQ-041 Nominal: enable=1, busy=0 -> valid=1 with msg 0001 two cycles later; busy pulse falls -> valid=0; Done_resp -> Module_end=1 next cycle; partner_end=1 -> CAL_end=1 one cycle later.
REQ-042 Busy held: busy=1 for 10 cycles after enable -> valid stays 0 throughout, and valid=1 on the cycle after busy drops.
REQ-043 Early response: Done_resp arrives during SEND_REQ, before the falling edge -> DONE reached the cycle after the falling edge, with no further wait.
REQ-044 Abort: enable drops during WAIT_RESP -> all outputs 0 next cycle; a later Done_resp has no effect.
REQ-045 Timeout (CAL_TIMEOUT_EN, TIMEOUT_CYCLES=16): no response -> o_train_error_req=1 at 16 cycles after leaving IDLE; a resp coinciding with expiry -> DONE instead, error stays 0.
REQ-046 Async reset pulse mid-SEND_REQ -> all outputs 0 immediately, IDLE after release.
